// File: rtl/hack_fetch_unit.sv
// hack_fetch_unit: owns the PC, fetches from the boot ROM and buffers words in a 2-entry queue.
// Optional FETCH_RANGE_CHECK_EN: a fetch at or beyond ROM_DEPTH pushes 0, sets range_fault and halts.
module hack_fetch_unit #(
   parameter logic [15:0] BOOT_ADDR = 16'h0000,
   parameter int          ROM_DEPTH = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   output logic [15:0] rom_addr,
   input  logic [15:0] rom_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_instr,
   output logic [15:0] out_pc,
   input  logic        jmp_valid,
   input  logic [15:0] jmp_addr,
   input  logic        halt_req,
   output logic        halted,
   output logic        range_fault
);
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;

   state_t      state_reg, state_next;
   logic [15:0] fetch_pc_reg, fetch_pc_next;
   logic [1:0]  count_reg, count_next;
   logic [15:0] ent_pc_reg [2];
   logic [15:0] ent_instr_reg [2];
   logic [15:0] ent_pc_next [2];
   logic [15:0] ent_instr_next [2];

   logic        jump, pop, fetch, range_halt;
   logic [15:0] push_instr;
   logic [1:0]  base_count;

   assign out_valid = (count_reg != 2'd0);
   assign pop       = out_valid && out_ready;
   assign jump      = (state_reg != IDLE) && jmp_valid;
   assign fetch     = (state_reg == RUN) && !jmp_valid && ((count_reg < 2'd2) || pop);
   assign rom_addr  = fetch_pc_reg;
   assign out_pc    = ent_pc_reg[0];
   assign out_instr = ent_instr_reg[0];
   assign halted    = (state_reg == HALT);

`ifdef FETCH_RANGE_CHECK_EN
   localparam logic [16:0] ROM_LIMIT = 17'(ROM_DEPTH);
   logic range_fault_reg;

   assign range_halt  = fetch && ({1'b0, fetch_pc_reg} >= ROM_LIMIT);
   assign push_instr  = range_halt ? 16'h0000 : rom_data;
   assign range_fault = range_fault_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         range_fault_reg <= 1'b0;
      end else if (range_halt) begin
         range_fault_reg <= 1'b1;
      end
   end
`else
   assign range_halt  = 1'b0;
   assign push_instr  = rom_data;
   assign range_fault = 1'b0;
`endif

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (en) state_next = RUN;
         end
         RUN: begin
            // a jump wins over halt and keeps the stage running
            if (jmp_valid)       state_next = RUN;
            else if (halt_req)   state_next = HALT;
            else if (range_halt) state_next = HALT;
            else if (!en)        state_next = IDLE;
         end
         HALT: begin
            if (jmp_valid) state_next = RUN;
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      fetch_pc_next = fetch_pc_reg;
      if (jump) begin
         fetch_pc_next = jmp_addr;
      end else if (fetch && !range_halt) begin
         fetch_pc_next = fetch_pc_reg + 16'd1;
      end
   end

   // Pop shifts the tail forward first, then a push lands at the first free slot.
   always_comb begin
      ent_pc_next    = ent_pc_reg;
      ent_instr_next = ent_instr_reg;
      count_next     = count_reg;
      base_count     = count_reg - {1'b0, pop};
      if (jump) begin
         count_next = 2'd0;
      end else begin
         if (pop) begin
            ent_pc_next[0]    = ent_pc_reg[1];
            ent_instr_next[0] = ent_instr_reg[1];
            count_next        = base_count;
         end
         if (fetch) begin
            if (base_count == 2'd0) begin
               ent_pc_next[0]    = fetch_pc_reg;
               ent_instr_next[0] = push_instr;
            end else begin
               ent_pc_next[1]    = fetch_pc_reg;
               ent_instr_next[1] = push_instr;
            end
            count_next = base_count + 2'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         fetch_pc_reg <= BOOT_ADDR;
         count_reg    <= 2'd0;
      end else begin
         state_reg    <= state_next;
         fetch_pc_reg <= fetch_pc_next;
         count_reg    <= count_next;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_entry
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               ent_pc_reg[gi]    <= 16'h0000;
               ent_instr_reg[gi] <= 16'h0000;
            end else begin
               ent_pc_reg[gi]    <= ent_pc_next[gi];
               ent_instr_reg[gi] <= ent_instr_next[gi];
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_hack_fetch_unit.sv
// Self-checking bench for hack_fetch_unit: directed scenarios plus randomized traffic
// against a queue-based reference model of the fetch stage.
module tb_hack_fetch_unit;
   localparam logic [15:0] BOOT = 16'h0000;
`ifdef FETCH_RANGE_CHECK_EN
   localparam bit RANGE_EN = 1'b1;
`else
   localparam bit RANGE_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n, en, out_ready, jmp_valid, halt_req;
   logic [15:0] jmp_addr;
   logic [15:0] rom_addr, rom_data, out_instr, out_pc;
   logic        out_valid, halted, range_fault;
   logic [15:0] rom [256];

   int n_checks = 0;
   int n_pass   = 0;

   hack_fetch_unit #(.BOOT_ADDR(BOOT), .ROM_DEPTH(256)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .rom_addr(rom_addr), .rom_data(rom_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
      .jmp_valid(jmp_valid), .jmp_addr(jmp_addr), .halt_req(halt_req),
      .halted(halted), .range_fault(range_fault)
   );

   assign rom_data = rom[rom_addr[7:0]];
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1)
         $display("xfer pc=%h instr=%h", out_pc, out_instr);
   end

   // Reference model: state 0 idle, 1 run, 2 halt; queue entries are {pc, instr}.
   int          m_state;
   logic [15:0] m_pc;
   logic [31:0] mq [$];
   bit          m_fault;

   function automatic void model_reset();
      m_state = 0;
      m_pc    = BOOT;
      mq.delete();
      m_fault = 1'b0;
   endfunction

   function automatic void model_step();
      bit pop, do_fetch, oor;
      int nxt;
      pop = (mq.size() != 0) && out_ready;
      nxt = m_state;
      oor = 1'b0;
      if (m_state != 0 && jmp_valid) begin
         mq.delete();
         m_pc = jmp_addr;
         nxt  = 1;
      end else begin
         do_fetch = (m_state == 1) && (mq.size() < 2 || pop);
         oor = do_fetch && RANGE_EN && (m_pc >= 16'd256);
         if (pop) void'(mq.pop_front());
         if (do_fetch) begin
            mq.push_back({m_pc, oor ? 16'h0000 : rom[m_pc[7:0]]});
            if (oor) m_fault = 1'b1;
            else     m_pc = m_pc + 16'd1;
         end
         if (m_state == 0 && en) nxt = 1;
         else if (m_state == 1) begin
            if (halt_req || oor) nxt = 2;
            else if (!en)        nxt = 0;
         end
      end
      m_state = nxt;
   endfunction

   function automatic logic [50:0] exp_obs();
      logic        v;
      logic [31:0] h;
      v = (mq.size() != 0);
      h = v ? mq[0] : 32'h0;
      return {v, h, m_pc, (m_state == 2), m_fault};
   endfunction

   function automatic logic [50:0] dut_obs();
      return {out_valid, (out_valid ? {out_pc, out_instr} : 32'h0), rom_addr, halted, range_fault};
   endfunction

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_rom();
      for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; en = 1'b0; out_ready = 1'b0; jmp_valid = 1'b0; halt_req = 1'b0; jmp_addr = 16'h0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      logic [50:0] o, e;
      fill_rom();
      rst_n = 1'b0; en = 1'b1; out_ready = 1'b1; jmp_valid = 1'b0; halt_req = 1'b0; jmp_addr = 16'h0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else n_pass++;
      n_checks++;
      if ({out_pc, out_instr} !== 32'h0) $display("FAIL reset_head: got %h want 0", {out_pc, out_instr}); else n_pass++;
      n_checks++;
      if (rom_addr !== BOOT) $display("FAIL reset_rom_addr: got %h want %h", rom_addr, BOOT); else n_pass++;
      n_checks++;
      if ({halted, range_fault} !== 2'b00) $display("FAIL reset_flags: got %b want 00", {halted, range_fault}); else n_pass++;
      #2 rst_n = 1'b1; en = 1'b0;
      model_reset();
      repeat (2) begin
         cycle();
         o = dut_obs(); e = exp_obs();
         n_checks++;
         if (o !== e) $display("FAIL reset_idle: got %h want %h", o, e); else n_pass++;
      end
   endtask

   task automatic test_stream();
      logic [15:0] words [4];
      logic [50:0] o, e;
      words = '{16'h0010, 16'hEC10, 16'h0011, 16'hE308};
      fill_rom();
      for (int i = 0; i < 4; i++) rom[i] = words[i];
      do_reset();
      en = 1'b1; out_ready = 1'b1;
      cycle();
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL stream_latency: got valid %b want 0", out_valid); else n_pass++;
      cycle();
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (out_valid !== 1'b1 || out_pc !== 16'(i) || out_instr !== words[i])
            $display("FAIL stream_word %0d: got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h",
                     i, out_valid, out_pc, out_instr, 16'(i), words[i]);
         else n_pass++;
         o = dut_obs(); e = exp_obs();
         n_checks++;
         if (o !== e) $display("FAIL stream_obs %0d: got %h want %h", i, o, e); else n_pass++;
         cycle();
      end
   endtask

   task automatic test_backpressure();
      logic [50:0] o, e;
      fill_rom();
      do_reset();
      en = 1'b1; out_ready = 1'b1;
      cycle(); cycle();
      out_ready = 1'b0;
      repeat (5) begin
         cycle();
         o = dut_obs(); e = exp_obs();
         n_checks++;
         if (o !== e) $display("FAIL bp_hold_obs: got %h want %h", o, e); else n_pass++;
      end
      n_checks++;
      if (rom_addr !== 16'h0002 || out_pc !== 16'h0000 || out_valid !== 1'b1)
         $display("FAIL bp_saturate: got addr=%h pc=%h v=%b want addr=0002 pc=0000 v=1", rom_addr, out_pc, out_valid);
      else n_pass++;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (out_valid !== 1'b1 || out_pc !== 16'(i) || out_instr !== rom[i])
            $display("FAIL bp_release %0d: got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h",
                     i, out_valid, out_pc, out_instr, 16'(i), rom[i]);
         else n_pass++;
         cycle();
      end
   endtask

   task automatic test_jump();
      logic [50:0] o, e;
      fill_rom();
      do_reset();
      en = 1'b1; out_ready = 1'b0;
      repeat (3) cycle();
      o = dut_obs(); e = exp_obs();
      n_checks++;
      if (o !== e) $display("FAIL jump_prefill: got %h want %h", o, e); else n_pass++;
      jmp_valid = 1'b1; jmp_addr = 16'h0040;
      cycle();
      jmp_valid = 1'b0; out_ready = 1'b1;
      n_checks++;
      if (out_valid !== 1'b0 || rom_addr !== 16'h0040)
         $display("FAIL jump_flush: got v=%b addr=%h want v=0 addr=0040", out_valid, rom_addr);
      else n_pass++;
      cycle();
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== 16'h0040 || out_instr !== rom[64])
         $display("FAIL jump_target: got v=%b pc=%h instr=%h want v=1 pc=0040 instr=%h",
                  out_valid, out_pc, out_instr, rom[64]);
      else n_pass++;
      for (int i = 1; i < 4; i++) begin
         cycle();
         n_checks++;
         if (out_valid !== 1'b1 || out_pc !== 16'h0040 + 16'(i))
            $display("FAIL jump_follow %0d: got v=%b pc=%h want v=1 pc=%h", i, out_valid, out_pc, 16'h0040 + 16'(i));
         else n_pass++;
      end
   endtask

   task automatic test_wrap();
      logic [15:0] want;
      logic [50:0] o, e;
      fill_rom();
      do_reset();
      en = 1'b1; out_ready = 1'b1;
      cycle();
      jmp_valid = 1'b1; jmp_addr = 16'hFFFE;
      cycle();
      jmp_valid = 1'b0;
`ifdef FETCH_RANGE_CHECK_EN
      cycle();
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== 16'hFFFE || out_instr !== 16'h0000 || halted !== 1'b1 || range_fault !== 1'b1)
         $display("FAIL wrap_range_fault: got v=%b pc=%h instr=%h halted=%b rf=%b want 1 FFFE 0000 1 1",
                  out_valid, out_pc, out_instr, halted, range_fault);
      else n_pass++;
      cycle();
      n_checks++;
      if (out_valid !== 1'b0 || rom_addr !== 16'hFFFE || range_fault !== 1'b1)
         $display("FAIL wrap_range_stop: got v=%b addr=%h rf=%b want 0 FFFE 1", out_valid, rom_addr, range_fault);
      else n_pass++;
      o = dut_obs(); e = exp_obs();
      n_checks++;
      if (o !== e) $display("FAIL wrap_range_obs: got %h want %h", o, e); else n_pass++;
`else
      for (int i = 0; i < 4; i++) begin
         cycle();
         want = 16'hFFFE + 16'(i);
         n_checks++;
         if (out_valid !== 1'b1 || out_pc !== want || out_instr !== rom[want[7:0]] || range_fault !== 1'b0)
            $display("FAIL wrap_seq %0d: got v=%b pc=%h instr=%h rf=%b want v=1 pc=%h instr=%h rf=0",
                     i, out_valid, out_pc, out_instr, range_fault, want, rom[want[7:0]]);
         else n_pass++;
         o = dut_obs(); e = exp_obs();
         n_checks++;
         if (o !== e) $display("FAIL wrap_obs %0d: got %h want %h", i, o, e); else n_pass++;
      end
`endif
   endtask

   task automatic test_halt();
      fill_rom();
      do_reset();
      en = 1'b1; out_ready = 1'b0;
      repeat (3) cycle();
      halt_req = 1'b1;
      cycle();
      halt_req = 1'b0;
      n_checks++;
      if (halted !== 1'b1 || rom_addr !== 16'h0002 || out_pc !== 16'h0000)
         $display("FAIL halt_enter: got halted=%b addr=%h pc=%h want 1 0002 0000", halted, rom_addr, out_pc);
      else n_pass++;
      out_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (out_valid !== 1'b1 || out_pc !== 16'(i) || out_instr !== rom[i])
            $display("FAIL halt_drain %0d: got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h",
                     i, out_valid, out_pc, out_instr, 16'(i), rom[i]);
         else n_pass++;
         cycle();
      end
      repeat (3) cycle();
      n_checks++;
      if (out_valid !== 1'b0 || rom_addr !== 16'h0002 || halted !== 1'b1)
         $display("FAIL halt_nofetch: got v=%b addr=%h halted=%b want 0 0002 1", out_valid, rom_addr, halted);
      else n_pass++;
      jmp_valid = 1'b1; jmp_addr = 16'h0005;
      cycle();
      jmp_valid = 1'b0;
      n_checks++;
      if (halted !== 1'b0) $display("FAIL halt_resume_state: got halted=%b want 0", halted); else n_pass++;
      cycle();
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== 16'h0005 || out_instr !== rom[5])
         $display("FAIL halt_resume: got v=%b pc=%h instr=%h want v=1 pc=0005 instr=%h", out_valid, out_pc, out_instr, rom[5]);
      else n_pass++;
   endtask

   task automatic test_async_reset();
      logic [50:0] o, e;
      fill_rom();
      do_reset();
      en = 1'b1; out_ready = 1'b0;
      repeat (3) cycle();
      o = dut_obs(); e = exp_obs();
      n_checks++;
      if (o !== e) $display("FAIL areset_prefill: got %h want %h", o, e); else n_pass++;
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || rom_addr !== BOOT || out_pc !== 16'h0000)
         $display("FAIL areset_async: got v=%b addr=%h pc=%h want 0 %h 0000", out_valid, rom_addr, out_pc, BOOT);
      else n_pass++;
      @(posedge clk);
      #3 rst_n = 1'b1; en = 1'b0;
      model_reset();
      cycle();
      n_checks++;
      if (out_valid !== 1'b0 || halted !== 1'b0 || rom_addr !== BOOT)
         $display("FAIL areset_idle: got v=%b halted=%b addr=%h want 0 0 %h", out_valid, halted, rom_addr, BOOT);
      else n_pass++;
      en = 1'b1;
      cycle();
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL areset_leave_idle: got v=%b want 0", out_valid); else n_pass++;
      cycle();
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== BOOT || out_instr !== rom[0])
         $display("FAIL areset_first: got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h", out_valid, out_pc, out_instr, BOOT, rom[0]);
      else n_pass++;
   endtask

   task automatic test_random();
      logic [50:0] o, e;
      fill_rom();
      do_reset();
      for (int i = 0; i < 600; i++) begin
         en        = ($urandom_range(0, 9) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         halt_req  = ($urandom_range(0, 29) == 0);
         jmp_valid = ($urandom_range(0, 19) == 0);
         jmp_addr  = ($urandom_range(0, 7) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3))
                                                 : 16'($urandom_range(0, 255));
         cycle();
         o = dut_obs(); e = exp_obs();
         n_checks++;
         if (o !== e) $display("FAIL random_obs cyc %0d: got %h want %h", i, o, e); else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_jump();
      test_wrap();
      test_halt();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
